// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator and its receive-side checker.
package lfsr_pkg;

  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } lfsr_state_e;

  localparam int unsigned SEQ_PERIOD = 12;

  // Bit i of each table describes the window W == i (newest bit at W[0]).
  // Windows 0000, 0101, 1010 and 1111 never occur in the 12-state sequence.
  localparam logic [15:0] NEXT_VALID = 16'h7BDE;
  localparam logic [15:0] NEXT_BIT   = 16'h3942;

endpackage

// File: rtl/lfsr_checker_if.sv
// Serial receive bus and status outputs of the LFSR checker.
// LFSR_CHECKER_STICKY_EN adds the err_sticky status bit.
interface lfsr_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             en;
  logic             din;
  logic             locked;
  logic             bit_err;
  logic [ERR_W-1:0] err_count;
`ifdef LFSR_CHECKER_STICKY_EN
  logic             err_sticky;

  modport master (output en, din, input locked, bit_err, err_count, err_sticky);
  modport slave  (input en, din, output locked, bit_err, err_count, err_sticky);
`else
  modport master (output en, din, input locked, bit_err, err_count);
  modport slave  (input en, din, output locked, bit_err, err_count);
`endif
endinterface

// File: rtl/lfsr_next_bit.sv
// Combinational next-bit lookup for the 12-state LFSR sequence: window -> {valid, pred}.
module lfsr_next_bit
  import lfsr_pkg::*;
(
  input  logic [3:0] w_i,
  output logic       valid_o,
  output logic       pred_o
);

  assign valid_o = NEXT_VALID[w_i];
  assign pred_o  = NEXT_BIT[w_i];

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: acquires lock from the serial stream, then flywheels and flags errors.
// LFSR_CHECKER_STICKY_EN adds a sticky error flag cleared only by reset.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned ERR_W       = 8
) (
  input logic           clk,
  input logic           rst,
  lfsr_checker_if.slave bus
);

  lfsr_state_e      state_q, state_d;
  logic [3:0]       w_q, w_d;
  logic [2:0]       fill_q, fill_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic             bit_err_q, bit_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic valid;
  logic pred;
  logic match;

  lfsr_next_bit u_next_bit (
    .w_i     (w_q),
    .valid_o (valid),
    .pred_o  (pred)
  );

  assign match = (bus.din == pred);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    fill_d    = fill_q;
    good_d    = good_q;
    bad_d     = bad_q;
    bit_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (bus.en) begin
      unique case (state_q)
        StHunt: begin
          w_d = {w_q[2:0], bus.din};
          if (fill_q != 3'd4) begin
            fill_d = fill_q + 3'd1;
          end else if (valid && match) begin
            if (good_q == 4'(LOCK_THRESH - 1)) begin
              state_d = StLocked;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 4'd1;
            end
          end else begin
            good_d = '0;
          end
        end
        StLocked: begin
          // Flywheel: the local window advances on its own prediction, never on Din.
          w_d = {w_q[2:0], pred};
          if (match) begin
            bad_d = '0;
          end else begin
            bit_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (bad_q == 4'(LOSS_THRESH - 1)) begin
              state_d = StHunt;
              fill_d  = '0;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHunt;
      w_q       <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      bit_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      bit_err_q <= bit_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked    = (state_q == StLocked);
  assign bus.bit_err   = bit_err_q;
  assign bus.err_count = err_cnt_q;

`ifdef LFSR_CHECKER_STICKY_EN
  logic sticky_q, sticky_d;

  assign sticky_d = sticky_q | bit_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: an ERR_W=8 and an ERR_W=2 instance share one stimulus stream.
module tb_lfsr_checker;

  localparam int LockThresh = 4;
  localparam int LossThresh = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(8)) bus_a ();
  lfsr_checker_if #(.ERR_W(2)) bus_b ();

  assign bus_b.en  = bus_a.en;
  assign bus_b.din = bus_a.din;

  lfsr_checker #(
    .LOCK_THRESH (LockThresh),
    .LOSS_THRESH (LossThresh),
    .ERR_W       (8)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  lfsr_checker #(
    .LOCK_THRESH (LockThresh),
    .LOSS_THRESH (LossThresh),
    .ERR_W       (2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic       locked;
    logic       bit_err;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       sticky;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Canonical stream, first bit in the MSB.
  logic [11:0] canon_bits = 12'b1101_1100_1000;

  logic [3:0] m_w;
  int         m_fill, m_good, m_bad, m_cnt_a, m_cnt_b;
  bit         m_lock, m_err, m_sticky;
  int         sidx;
  int         pulses;
  int         en_bits;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tbl_valid(input logic [3:0] w);
    return !(w == 4'b0000 || w == 4'b0101 || w == 4'b1010 || w == 4'b1111);
  endfunction

  function automatic bit tbl_pred(input logic [3:0] w);
    case (w)
      4'b1101, 4'b1011, 4'b1100, 4'b1000, 4'b0001, 4'b0110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_w      = 4'b0000;
    m_fill   = 0;
    m_good   = 0;
    m_bad    = 0;
    m_cnt_a  = 0;
    m_cnt_b  = 0;
    m_lock   = 1'b0;
    m_err    = 1'b0;
    m_sticky = 1'b0;
    sidx     = 0;
    pulses   = 0;
  endfunction

  // Drive one cycle, push the model's post-edge expectation, then pop and compare.
  task automatic step(input bit en, input bit din);
    bit   p;
    bit   v;
    exp_t e;
    @(negedge clk);
    bus_a.en  = en;
    bus_a.din = din;
    m_err     = 1'b0;
    if (en) begin
      v = tbl_valid(m_w);
      p = tbl_pred(m_w);
      if (!m_lock) begin
        if (m_fill == 4 && v && din == p) begin
          m_good++;
          if (m_good == LockThresh) begin
            m_lock = 1'b1;
            m_good = 0;
            m_bad  = 0;
          end
        end else if (m_fill == 4) begin
          m_good = 0;
        end
        m_w = {m_w[2:0], din};
        if (m_fill < 4) m_fill++;
      end else begin
        if (din == p) begin
          m_bad = 0;
        end else begin
          m_err    = 1'b1;
          m_sticky = 1'b1;
          if (m_cnt_a < 255) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
          m_bad++;
          if (m_bad == LossThresh) begin
            m_lock = 1'b0;
            m_fill = 0;
            m_good = 0;
            m_bad  = 0;
          end
        end
        m_w = {m_w[2:0], p};
      end
    end
    sb_q.push_back('{locked: m_lock, bit_err: m_err, cnt_a: 8'(m_cnt_a), cnt_b: 2'(m_cnt_b),
                     sticky: m_sticky});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (bus_a.bit_err === 1'b1) pulses++;
    check_eq("locked_a", 32'(bus_a.locked), 32'(e.locked));
    check_eq("locked_b", 32'(bus_b.locked), 32'(e.locked));
    check_eq("bit_err_a", 32'(bus_a.bit_err), 32'(e.bit_err));
    check_eq("bit_err_b", 32'(bus_b.bit_err), 32'(e.bit_err));
    check_eq("err_count_a", 32'(bus_a.err_count), 32'(e.cnt_a));
    check_eq("err_count_b", 32'(bus_b.err_count), 32'(e.cnt_b));
`ifdef LFSR_CHECKER_STICKY_EN
    check_eq("sticky_a", 32'(bus_a.err_sticky), 32'(e.sticky));
    check_eq("sticky_b", 32'(bus_b.err_sticky), 32'(e.sticky));
`endif
  endtask

  task automatic send_canon(input bit flip);
    step(1'b1, canon_bits[11 - (sidx % 12)] ^ flip);
    sidx++;
  endtask

  // Reset is raised away from the clock edge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_locked", 32'(bus_a.locked), 32'd0);
    check_eq("rst_bit_err", 32'(bus_a.bit_err), 32'd0);
    check_eq("rst_count_a", 32'(bus_a.err_count), 32'd0);
    check_eq("rst_count_b", 32'(bus_b.err_count), 32'd0);
`ifdef LFSR_CHECKER_STICKY_EN
    check_eq("rst_sticky", 32'(bus_a.err_sticky), 32'd0);
`endif
    model_reset();
    sb_q.delete();
    @(negedge clk);
    bus_a.en  = 1'b0;
    bus_a.din = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    bus_a.en  = 1'b0;
    bus_a.din = 1'b0;
    model_reset();
    do_reset();

    // Clean stream: lock after the 8th bit, no errors over 48 bits.
    for (int i = 0; i < 48; i++) begin
      send_canon(1'b0);
      if (i == 6) check_eq("clean_prelock", 32'(bus_a.locked), 32'd0);
      if (i == 7) check_eq("clean_lock8", 32'(bus_a.locked), 32'd1);
    end
    check_eq("clean_count", 32'(bus_a.err_count), 32'd0);
    check_eq("clean_pulses", 32'(pulses), 32'd0);

    // One inverted bit while locked.
    do_reset();
    for (int i = 0; i < 12; i++) send_canon(1'b0);
    send_canon(1'b1);
    for (int i = 0; i < 12; i++) send_canon(1'b0);
    check_eq("flip_pulses", 32'(pulses), 32'd1);
    check_eq("flip_count", 32'(bus_a.err_count), 32'd1);
    check_eq("flip_locked", 32'(bus_a.locked), 32'd1);

    // Din stuck low after lock: mismatches at preds 1,1,(0),1,1,1 -> loss after 5 errors.
    do_reset();
    for (int i = 0; i < 12; i++) send_canon(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check_eq("stuck_loss", 32'(bus_a.locked), 32'd0);
    check_eq("stuck_count", 32'(bus_a.err_count), 32'd5);

    // Stuck inputs from reset produce only invalid windows.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    check_eq("zeros_nolock", 32'(bus_a.locked), 32'd0);
    check_eq("zeros_count", 32'(bus_a.err_count), 32'd0);
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    check_eq("ones_nolock", 32'(bus_a.locked), 32'd0);
    check_eq("ones_count", 32'(bus_a.err_count), 32'd0);

    // Five isolated errors: the 2-bit counter saturates, lock is held.
    do_reset();
    for (int i = 0; i < 12; i++) send_canon(1'b0);
    for (int k = 0; k < 5; k++) begin
      send_canon(1'b1);
      for (int i = 0; i < 5; i++) send_canon(1'b0);
    end
    check_eq("sat_count_b", 32'(bus_b.err_count), 32'd3);
    check_eq("sat_count_a", 32'(bus_a.err_count), 32'd5);
    check_eq("sat_locked", 32'(bus_a.locked), 32'd1);
    check_eq("sat_pulses", 32'(pulses), 32'd5);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check_eq("sat_loss", 32'(bus_a.locked), 32'd0);
    check_eq("sat_count_kept", 32'(bus_b.err_count), 32'd3);
`ifdef LFSR_CHECKER_STICKY_EN
    check_eq("sticky_after_loss", 32'(bus_b.err_sticky), 32'd1);
`endif

    // Gapped enable: lock point counted in En bits; junk on idle cycles is ignored.
    do_reset();
    en_bits = 0;
    for (int j = 0; j < 24; j++) begin
      if (j % 3 == 0) begin
        send_canon(1'b0);
        en_bits++;
        if (en_bits == 7) check_eq("gap_prelock", 32'(bus_a.locked), 32'd0);
        if (en_bits == 8) check_eq("gap_lock8", 32'(bus_a.locked), 32'd1);
      end else begin
        step(1'b0, 1'($urandom));
      end
    end
    for (int j = 0; j < 30; j++) begin
      if (j % 3 == 0) send_canon(j == 9);
      else step(1'b0, 1'($urandom));
    end
    check_eq("gap_pulses", 32'(pulses), 32'd1);
    check_eq("gap_count", 32'(bus_a.err_count), 32'd1);
    check_eq("gap_locked", 32'(bus_a.locked), 32'd1);

    // Reset while locked clears everything at once.
    do_reset();
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
